vga_sync_timing: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_sync_timing_if.sv | 26 ++
 rtl/vga_axis_counter.sv | 67 ++++++
 rtl/vga_sync_timing.sv | 93 +++++++++
 tb/tb_vga_sync_timing.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants, counter type and control-state encoding
// for the VGA sync generator and its axis counters.
package vga_timing_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  function automatic int axis_sync_first(input int display, input int front);
    return display + front;
  endfunction

  function automatic int axis_sync_last(input int display, input int front,
                                        input int sync);
    return display + front + sync - 1;
  endfunction

  localparam int DEF_H_TOTAL      = axis_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL      = axis_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  localparam int DEF_H_SYNC_START = axis_sync_first(DEF_H_DISPLAY, DEF_H_FRONT);
  localparam int DEF_H_SYNC_END   = axis_sync_last(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC);
  localparam int DEF_V_SYNC_START = axis_sync_first(DEF_V_DISPLAY, DEF_V_FRONT);
  localparam int DEF_V_SYNC_END   = axis_sync_last(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC);

  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/vga_sync_timing_if.sv
// Raster bundle between the sync generator and the pixel-drawing logic.
interface vga_sync_timing_if;

  logic                  pix_ce;
  logic                  vga_h_sync;
  logic                  vga_v_sync;
  logic                  inDisplayArea;
  vga_timing_pkg::cnt_t  CounterX;
  vga_timing_pkg::cnt_t  CounterY;
  logic                  line_start;
  logic                  frame_start;
  logic                  vblank_start;

  modport master (
    input  pix_ce,
    output vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY,
           line_start, frame_start, vblank_start
  );

  modport slave (
    output pix_ce,
    input  vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY,
           line_start, frame_start, vblank_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync-window and
// display-window flags that always describe the registered count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = DEF_H_DISPLAY,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic load0,
  output cnt_t count,
  output logic wrap,
  output logic sync_active,
  output logic in_display
);

  localparam int   TOTAL      = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam cnt_t LAST       = cnt_t'(TOTAL - 1);
  localparam cnt_t SYNC_FIRST = cnt_t'(axis_sync_first(DISPLAY, FRONT));
  localparam cnt_t SYNC_LAST  = cnt_t'(axis_sync_last(DISPLAY, FRONT, SYNC));
  localparam cnt_t DISP_END   = cnt_t'(DISPLAY);

  if (TOTAL > MAX_TOTAL || SYNC < 1 || DISPLAY < 1) begin : g_bad_timing
    $error("vga_axis_counter: invalid timing, total %0d (limit %0d)", TOTAL, MAX_TOTAL);
  end

  cnt_t count_reg;
  cnt_t count_next;
  logic sync_reg;
  logic disp_reg;
  logic advance;

  assign wrap    = (count_reg == LAST);
  assign advance = load0 | ce;

  // Wrap is an explicit compare against the last position so any TOTAL works.
  always_comb begin
    count_next = count_reg;
    if (load0) begin
      count_next = '0;
    end else if (ce) begin
      count_next = wrap ? '0 : count_reg + cnt_t'(1);
    end
  end

  // Flags are computed from the next count so they land with it, skew-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      sync_reg  <= 1'b0;
      disp_reg  <= 1'b0;
    end else if (advance) begin
      count_reg <= count_next;
      sync_reg  <= (count_next >= SYNC_FIRST) && (count_next <= SYNC_LAST);
      disp_reg  <= (count_next < DISP_END);
    end
  end

  assign count       = count_reg;
  assign sync_active = sync_reg;
  assign in_display  = disp_reg;

endmodule

// File: rtl/vga_sync_timing.sv
// VGA raster timing generator: horizontal/vertical counters, sync pulses,
// display qualifier and single-clk line/frame/vblank strobes.
module vga_sync_timing
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY   = DEF_H_DISPLAY,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_DISPLAY   = DEF_V_DISPLAY,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  vga_sync_timing_if.master  vga
);

  localparam cnt_t VBLANK_LINE = cnt_t'(V_DISPLAY - 1);

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic       priming;
  logic       running;
  logic [1:0] axis_ce;
  logic [1:0] axis_wrap;
  logic [1:0] axis_sync;
  logic [1:0] axis_disp;
  cnt_t       axis_count [2];
  logic       line_start_reg;
  logic       frame_start_reg;
  logic       vblank_start_reg;

  assign priming = (state_reg == ST_PRIME) && vga.pix_ce;
  assign running = (state_reg == ST_RUN) && vga.pix_ce;

  // The vertical axis only ever steps on a horizontal wrap.
  assign axis_ce[0] = running;
  assign axis_ce[1] = running && axis_wrap[0];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_axis
    vga_axis_counter #(
      .DISPLAY (gi == 0 ? H_DISPLAY : V_DISPLAY),
      .FRONT   (gi == 0 ? H_FRONT   : V_FRONT),
      .SYNC    (gi == 0 ? H_SYNC    : V_SYNC),
      .BACK    (gi == 0 ? H_BACK    : V_BACK)
    ) u_axis (
      .clk         (clk),
      .reset       (reset),
      .ce          (axis_ce[gi]),
      .load0       (priming),
      .count       (axis_count[gi]),
      .wrap        (axis_wrap[gi]),
      .sync_active (axis_sync[gi]),
      .in_display  (axis_disp[gi])
    );
  end

  always_comb begin
    state_next = state_reg;
    if (priming) begin
      state_next = ST_RUN;
    end
  end

  // Strobes are rebuilt every clk, so they fall as soon as pix_ce drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_PRIME;
      line_start_reg   <= 1'b0;
      frame_start_reg  <= 1'b0;
      vblank_start_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      line_start_reg   <= priming || (running && axis_wrap[0]);
      frame_start_reg  <= priming || (running && axis_wrap[0] && axis_wrap[1]);
      vblank_start_reg <= running && axis_wrap[0] && (axis_count[1] == VBLANK_LINE);
    end
  end

  assign vga.CounterX      = axis_count[0];
  assign vga.CounterY      = axis_count[1];
  assign vga.inDisplayArea = axis_disp[0] & axis_disp[1];
  assign vga.vga_h_sync    = axis_sync[0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga.vga_v_sync    = axis_sync[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vga.line_start    = line_start_reg;
  assign vga.frame_start   = frame_start_reg;
  assign vga.vblank_start  = vblank_start_reg;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Self-checking bench: three timing configurations driven in lockstep and
// compared against a linear-position raster model every clk.
module tb_vga_sync_timing;

  localparam int N = 3;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic pix_ce = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  vga_sync_timing_if if_a ();
  vga_sync_timing_if if_b ();
  vga_sync_timing_if if_c ();
  assign if_a.pix_ce = pix_ce;
  assign if_b.pix_ce = pix_ce;
  assign if_c.pix_ce = pix_ce;

  vga_sync_timing #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b0)
  ) dut_a (.clk(clk), .reset(reset), .vga(if_a));

  vga_sync_timing #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b1)
  ) dut_b (.clk(clk), .reset(reset), .vga(if_b));

  vga_sync_timing dut_c (.clk(clk), .reset(reset), .vga(if_c));

  // {h_sync, v_sync, de, x[9:0], y[9:0], line_start, frame_start, vblank_start}
  logic [25:0] got [N];
  assign got[0] = {if_a.vga_h_sync, if_a.vga_v_sync, if_a.inDisplayArea, if_a.CounterX,
                   if_a.CounterY, if_a.line_start, if_a.frame_start, if_a.vblank_start};
  assign got[1] = {if_b.vga_h_sync, if_b.vga_v_sync, if_b.inDisplayArea, if_b.CounterX,
                   if_b.CounterY, if_b.line_start, if_b.frame_start, if_b.vblank_start};
  assign got[2] = {if_c.vga_h_sync, if_c.vga_v_sync, if_c.inDisplayArea, if_c.CounterX,
                   if_c.CounterY, if_c.line_start, if_c.frame_start, if_c.vblank_start};

  int   m_hd [N] = '{4, 8, 640};
  int   m_hf [N] = '{1, 2, 16};
  int   m_hs [N] = '{2, 3, 96};
  int   m_ht [N] = '{8, 15, 800};
  int   m_vd [N] = '{3, 5, 480};
  int   m_vf [N] = '{1, 1, 10};
  int   m_vs [N] = '{1, 2, 2};
  int   m_vt [N] = '{6, 10, 525};
  logic m_sa [N] = '{1'b0, 1'b1, 1'b0};

  // Model: raster position as one linear pixel index within the frame.
  logic m_primed [N];
  int   m_pos    [N];
  logic m_ls     [N];
  logic m_fs     [N];
  logic m_vb     [N];

  function automatic logic [25:0] expected(input int i);
    int   x, y, hs0, vs0;
    logic h_on, v_on, de;
    x    = m_pos[i] % m_ht[i];
    y    = m_pos[i] / m_ht[i];
    hs0  = m_hd[i] + m_hf[i];
    vs0  = m_vd[i] + m_vf[i];
    h_on = m_primed[i] && (x >= hs0) && (x < hs0 + m_hs[i]);
    v_on = m_primed[i] && (y >= vs0) && (y < vs0 + m_vs[i]);
    de   = m_primed[i] && (x < m_hd[i]) && (y < m_vd[i]);
    return {h_on ? m_sa[i] : ~m_sa[i], v_on ? m_sa[i] : ~m_sa[i], de,
            10'(x), 10'(y), m_ls[i], m_fs[i], m_vb[i]};
  endfunction

  task automatic tick(input logic ce, input logic rst);
    @(negedge clk);
    pix_ce = ce;
    reset  = rst;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_primed[i] = 1'b0; m_pos[i] = 0;
        m_ls[i] = 1'b0; m_fs[i] = 1'b0; m_vb[i] = 1'b0;
      end else if (!ce) begin
        m_ls[i] = 1'b0; m_fs[i] = 1'b0; m_vb[i] = 1'b0;
      end else if (!m_primed[i]) begin
        m_primed[i] = 1'b1; m_pos[i] = 0;
        m_ls[i] = 1'b1; m_fs[i] = 1'b1; m_vb[i] = 1'b0;
      end else begin
        m_pos[i] = (m_pos[i] + 1) % (m_ht[i] * m_vt[i]);
        m_ls[i]  = (m_pos[i] % m_ht[i]) == 0;
        m_fs[i]  = m_pos[i] == 0;
        m_vb[i]  = m_pos[i] == m_vd[i] * m_ht[i];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (got[0] !== {1'b1, 1'b1, 1'b0, 20'd0, 3'b000}) begin
        n_fail++;
        $display("FAIL reset_a: got %h required %h", got[0], {1'b1, 1'b1, 1'b0, 20'd0, 3'b000});
      end
      n_checks++;
      if (got[1] !== 26'd0) begin
        n_fail++;
        $display("FAIL reset_b: got %h required %h", got[1], 26'd0);
      end
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (got[0] !== {1'b1, 1'b1, 1'b1, 20'd0, 3'b110}) begin
      n_fail++;
      $display("FAIL prime_a: got %h required %h", got[0], {1'b1, 1'b1, 1'b1, 20'd0, 3'b110});
    end
    tick(1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (got[i] !== expected(i)) begin
        n_fail++;
        $display("FAIL prime_hold inst%0d: got %h required %h", i, got[i], expected(i));
      end
    end
    $display("test_reset: done at cycle %0d", cyc);
  endtask

  task automatic test_default_line();
    int   last_ls = -1;
    int   run     = 0;
    logic prev_hs = 1'b1;
    logic prev_de = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      tick(1'b1, 1'b0);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got[i] !== expected(i)) begin
          n_fail++;
          $display("FAIL line_model inst%0d cyc %0d: got %h required %h", i, cyc, got[i], expected(i));
        end
      end
      if (if_c.line_start) begin
        if (last_ls >= 0) begin
          n_checks++;
          if (cyc - last_ls != 800) begin
            n_fail++;
            $display("FAIL line_period: got %0d required 800", cyc - last_ls);
          end
        end
        last_ls = cyc;
      end
      if (!if_c.vga_h_sync) begin
        if (prev_hs) begin
          n_checks++;
          if (if_c.CounterX !== 10'd656) begin
            n_fail++;
            $display("FAIL hsync_start: got x=%0d required 656", if_c.CounterX);
          end
        end
        run++;
      end else if (!prev_hs) begin
        n_checks++;
        if (run != 96) begin
          n_fail++;
          $display("FAIL hsync_width: got %0d required 96", run);
        end
        run = 0;
      end
      if (prev_de && !if_c.inDisplayArea && if_c.CounterY < 10'd480) begin
        n_checks++;
        if (if_c.CounterX !== 10'd640) begin
          n_fail++;
          $display("FAIL de_fall: got x=%0d required 640", if_c.CounterX);
        end
      end
      prev_hs = if_c.vga_h_sync;
      prev_de = if_c.inDisplayArea;
    end
    $display("test_default_line: done at cycle %0d", cyc);
  endtask

  task automatic test_small_frames();
    int vb_count = 0;
    int last_fs  = -1;
    for (int k = 0; k < 144; k++) begin
      tick(1'b1, 1'b0);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got[i] !== expected(i)) begin
          n_fail++;
          $display("FAIL frame_model inst%0d cyc %0d: got %h required %h", i, cyc, got[i], expected(i));
        end
      end
      if (if_a.vblank_start) vb_count++;
      if (if_a.frame_start) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (cyc - last_fs != 48) begin
            n_fail++;
            $display("FAIL frame_period: got %0d required 48", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
    end
    n_checks++;
    if (vb_count != 3) begin
      n_fail++;
      $display("FAIL vblank_count: got %0d required 3", vb_count);
    end
    $display("test_small_frames: done at cycle %0d", cyc);
  endtask

  task automatic test_half_rate();
    int last_ls = -1;
    int last_fs = -1;
    for (int k = 0; k < 400; k++) begin
      tick(k[0] == 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got[i] !== expected(i)) begin
          n_fail++;
          $display("FAIL half_model inst%0d cyc %0d: got %h required %h", i, cyc, got[i], expected(i));
        end
      end
      if (if_a.line_start) begin
        if (last_ls >= 0) begin
          n_checks++;
          if (cyc - last_ls != 16) begin
            n_fail++;
            $display("FAIL half_line_period: got %0d required 16", cyc - last_ls);
          end
        end
        last_ls = cyc;
      end
      if (if_a.frame_start) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (cyc - last_fs != 96) begin
            n_fail++;
            $display("FAIL half_frame_period: got %0d required 96", cyc - last_fs);
          end
        end
        last_fs = cyc;
      end
    end
    $display("test_half_rate: done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid_frame();
    logic found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick(1'b1, 1'b0);
      if (got[0][22:13] == 10'd5 && got[0][12:3] == 10'd4) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midreset_reach: got x=%0d y=%0d required x=5 y=4", got[0][22:13], got[0][12:3]);
    end
    n_checks++;
    if (got[0][25:24] !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_syncs_on: got %b required 00", got[0][25:24]);
    end
    tick(1'b1, 1'b1);
    n_checks++;
    if (got[0] !== {1'b1, 1'b1, 1'b0, 20'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL midreset_a: got %h required %h", got[0], {1'b1, 1'b1, 1'b0, 20'd0, 3'b000});
    end
    n_checks++;
    if (got[1] !== 26'd0) begin
      n_fail++;
      $display("FAIL midreset_b: got %h required %h", got[1], 26'd0);
    end
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (got[i] !== expected(i)) begin
        n_fail++;
        $display("FAIL midreset_restart inst%0d: got %h required %h", i, got[i], expected(i));
      end
    end
    n_checks++;
    if (got[0][2:1] !== 2'b11) begin
      n_fail++;
      $display("FAIL midreset_strobes: got %b required 11", got[0][2:1]);
    end
    $display("test_reset_mid_frame: done at cycle %0d", cyc);
  endtask

  task automatic test_random_ce();
    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (got[i] !== expected(i)) begin
          n_fail++;
          $display("FAIL random_model inst%0d cyc %0d: got %h required %h", i, cyc, got[i], expected(i));
        end
      end
    end
    $display("test_random_ce: done at cycle %0d", cyc);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_primed[i] = 1'b0; m_pos[i] = 0;
      m_ls[i] = 1'b0; m_fs[i] = 1'b0; m_vb[i] = 1'b0;
    end
    test_reset();
    test_default_line();
    test_small_frames();
    test_half_rate();
    test_reset_mid_frame();
    test_random_ce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
